// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO register pair with iterative multiply/divide engine
module hilo_muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [WIDTH-1:0]   opnd, a_mag, b_mag, quo, rem;
  logic               is_div, neg_q, neg_r;
  logic               is_muldiv, is_signed, zero_div, last, ge;
  logic [WIDTH:0]     add_sum, trial, diff;

  assign busy      = (state == RUN);
  assign is_muldiv = ~op[2];
  assign is_signed = ~op[0];
  assign zero_div  = op[1] && (b == '0);
  assign last      = (cnt == CNT_W'(WIDTH - 1));
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   acc = {partial remainder, remaining dividend/quotient bits}, shifted left.
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge      = (trial >= {1'b0, opnd});
  assign diff    = trial - {1'b0, opnd};

  always_comb begin
    acc_next = '0;
    if (is_div)
      acc_next = ge ? {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_next = {add_sum, acc[WIDTH-1:1]};
  end

  assign prod = neg_q ? -acc_next : acc_next;
  assign quo  = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
  assign rem  = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start && is_muldiv && !zero_div) state_d = RUN;
      RUN:  if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (op == 3'd4) begin
            hi <= a;
          end else if (op == 3'd5) begin
            lo <= a;
          end else if (is_muldiv) begin
            if (zero_div) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              cnt    <= '0;
              is_div <= op[1];
              neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= is_signed && op[1] && a[WIDTH-1];
              acc    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opnd   <= op[1] ? b_mag : a_mag;
            end
          end
        end
      end else begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        if (last) begin
          done <= 1'b1;
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed table-driven bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, busy, done, div_by_zero;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[9];

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drives one start request across a single rising edge, then scrambles operands.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd6; a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    logic seen_done;

    vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[8] = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};

    rst = 1'b1; start = 1'b0; op = 3'd6; a = '0; b = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_dbz", 64'(div_by_zero), 64'h0);
    rst = 1'b0;

    issue(3'd4, 32'h1234, 32'h0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'h0);
    issue(3'd5, 32'h5678, 32'h0);
    check("mtlo_lo", 64'(lo), 64'h5678);
    check("mtlo_hi_kept", 64'(hi), 64'h1234);
    check("mtlo_done", 64'(done), 64'h0);

    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    issue(3'd3, 32'd5, 32'h0);
    check("dbz_done", 64'(done), 64'h1);
    check("dbz_flag", 64'(div_by_zero), 64'h1);
    check("dbz_busy", 64'(busy), 64'h0);
    check("dbz_hi", 64'(hi), 64'h11);
    check("dbz_lo", 64'(lo), 64'h22);
    @(posedge clk); #1;
    check("dbz_done_drop", 64'(done), 64'h0);
    check("dbz_flag_drop", 64'(div_by_zero), 64'h0);

    issue(3'd1, 32'd3, 32'd4);
    check("busy_after_start", 64'(busy), 64'h1);
    issue(3'd4, 32'hABCD, 32'h0);
    check("mthi_while_busy_hi", 64'(hi), 64'h11);
    check("mfhi_old_value_lo", 64'(lo), 64'h22);
    wait_idle(cyc);
    check("busy_mthi_cycles", 64'(cyc), 64'(W - 1));
    check("busy_mthi_done", 64'(done), 64'h1);
    check("busy_mthi_hi", 64'(hi), 64'h0);
    check("busy_mthi_lo", 64'(lo), 64'd12);

    // Each vector starts in the cycle where the previous done is high.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'h1);
      wait_idle(cyc);
      check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(W));
      check($sformatf("v%0d_done", i), 64'(done), 64'h1);
      check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'h0);
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
    end
    @(posedge clk); #1;
    check("done_single_pulse", 64'(done), 64'h0);

    issue(3'd0, 32'd3, 32'd4);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_hi", 64'(hi), 64'h0);
    check("abort_lo", 64'(lo), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    seen_done = done;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    check("abort_no_done", 64'(seen_done), 64'h0);
    check("abort_hi_still", 64'(hi), 64'h0);
    issue(3'd1, 32'd3, 32'd4);
    wait_idle(cyc);
    check("after_abort_cycles", 64'(cyc), 64'(W));
    check("after_abort_hi", 64'(hi), 64'h0);
    check("after_abort_lo", 64'(lo), 64'd12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised HI/LO register pair combined with an iterative multiply/divide engine for the MIPS datapath. It executes MULT, MULTU, DIV, DIVU over WIDTH cycles and MTHI/MTLO in a single cycle. Results land in HI/LO, which feed MFHI/MFLO. A busy/done handshake lets the control unit stall the pipeline while an operation is in progress.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
a  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data).
b  input  WIDTH  rt operand (multiplier/divisor).
busy  output  1  high while an iterative operation runs.
done  output  1  one-cycle pulse when a MULT/DIV result is written or aborted.
div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0.
hi  output  WIDTH  HI register contents.
lo  output  WIDTH  LO register contents.

Behaviour:
- Reset: one clock with rst=1 sets hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, and clears the counter and working registers.
- rst has priority over every other input. Asserting rst mid-operation aborts the operation; no result is written.
- States: IDLE, RUN. done and div_by_zero are registered and default to 0 each cycle.

IDLE, start=1 at edge E:
- op=4 (MTHI): hi<=a at E. lo unchanged. No busy, no done.
- op=5 (MTLO): lo<=a at E. hi unchanged. No busy, no done.
- op=6/7: no effect.
- op=2/3 with b=0: no RUN. hi/lo unchanged. done=1 and div_by_zero=1 in the cycle after E.
- op=0..3 otherwise: latch operands, counter<=0, state<=RUN, busy=1 from E.
  - Signed ops (0, 2) latch magnitudes plus sign flags.
  - Magnitudes are treated as WIDTH-bit unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1).

RUN, one iteration per cycle:
- Multiply: shift-add; a 2*WIDTH-bit accumulator is built over WIDTH iterations.
- Divide: restoring division, one quotient bit per iteration.
- At the edge completing iteration WIDTH-1 (edge E+WIDTH):
  - Write the sign-corrected result into hi/lo.
  - state<=IDLE, busy<=0, done=1 in the following cycle.
- Total latency: result visible on hi/lo WIDTH cycles after the start edge. busy is high for exactly WIDTH cycles.

Result rules:
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - MULT negates the product when the operand signs differ.
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
  - Overflow case -2^(WIDTH-1)/-1: lo=0x80000000, hi=0, no flag (WIDTH=32).
- Arithmetic wraps to WIDTH bits. No exceptions are raised.

Boundary conditions:
- start while busy=1: ignored, including MTHI/MTLO. The control unit must stall.
- start in the cycle done=1: accepted normally (state is IDLE).
- hi/lo are never modified during RUN until the final write. MFHI during busy reads the old values.
- Operand inputs may change after the start edge without effect.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> busy high 32 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 exactly 32 cycles after start edge.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 with hi=0x11, lo=0x22 -> next cycle done=1, div_by_zero=1, busy never high, hi/lo unchanged.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles -> hi=0x1234 after first edge, lo=0x5678 after second. MTHI issued while busy -> hi unchanged.
- Start MULT 3*4, assert rst for 1 cycle at cycle 10 -> hi=lo=0, busy=0, done never pulses. A new MULTU 3*4 then yields lo=12, hi=0.
